// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver: FSM states, parity modes,
// and the counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } par_mode_e;

  // Bits needed to count 0..max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line, baud tick and parity select in; received
// word and per-frame status out.
interface uart_rx_cfg_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [1:0]      parity_mode;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            parity_err;
  logic            frame_err;
  logic            break_det;

  modport master (
    output rx, s_tick, parity_mode,
    input  rx_done_tick, dout, parity_err, frame_err, break_det
  );

  modport slave (
    input  rx, s_tick, parity_mode,
    output rx_done_tick, dout, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the asynchronous rx pad, plus a 2-of-3 majority
// voter over the last three s_tick samples when UART_RX_MAJORITY_EN is defined.
module uart_rx_sampler (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_i,
  input  logic s_tick_i,
  output logic rx_s_o,
  output logic bit_o
);

  logic [1:0] sync_q;

  // Reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_s_o = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is the previous tick's sample, hist_q[1] the one before.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 2'b11;
    end else if (s_tick_i) begin
      hist_q <= {hist_q[0], rx_s_o};
    end
  end

  assign bit_o = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_o) | (hist_q[0] & rx_s_o);
`else
  logic unused_tick;
  assign unused_tick = s_tick_i;
  assign bit_o       = rx_s_o;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DBIT data bits, OVS oversampling, SB_TICK stop
// ticks, runtime parity, parity/framing/break reporting. Option: UART_RX_MAJORITY_EN.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_rx_cfg_if.slave  bus
);

  localparam int S_W = cnt_width(OVS, SB_TICK);
  localparam int N_W = cnt_width(DBIT, 1);

`ifdef UART_RX_MAJORITY_EN
  // The vote window ends one tick after the centre, so the start check waits
  // for the third sample; every later bit commit shifts with it.
  localparam int START_CHK = OVS / 2;
`else
  localparam int START_CHK = OVS / 2 - 1;
`endif
  localparam int STOP_SMP = (SB_TICK < OVS) ? SB_TICK - 1 : OVS - 1;

  localparam logic [S_W-1:0] S_CHK  = S_W'(START_CHK);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
  localparam logic [S_W-1:0] S_SSMP = S_W'(STOP_SMP);
  localparam logic [S_W-1:0] S_END  = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  logic rx_s;
  logic bit_v;

  uart_rx_sampler u_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_i     (bus.rx),
    .s_tick_i (bus.s_tick),
    .rx_s_o   (rx_s),
    .bit_o    (bit_v)
  );

  rx_state_e       state_q;
  par_mode_e       mode_q;
  logic [S_W-1:0]  s_q;
  logic [N_W-1:0]  n_q;
  logic [DBIT-1:0] sh_q;
  logic            pbit_q;
  logic            perr_q;
  logic            stop_low_q;
  logic            done_q;
  logic [DBIT-1:0] dout_q;
  logic            parity_err_q;
  logic            frame_err_q;
  logic            break_det_q;

  logic par_en;
  logic ferr_now;

  assign par_en = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
  // With a short stop phase the sample and the end coincide; use the live bit.
  assign ferr_now = (s_q == S_SSMP) ? ~bit_v : stop_low_q;

  // NOTE: state registers use non-blocking assignments so every branch reads
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mode_q       <= PAR_NONE;
      s_q          <= '0;
      n_q          <= '0;
      sh_q         <= '0;
      pbit_q       <= 1'b0;
      perr_q       <= 1'b0;
      stop_low_q   <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_q     <= '0;
            mode_q  <= par_mode_e'(bus.parity_mode);
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s_q == S_CHK) begin
              if (bit_v) begin
                state_q <= IDLE;
              end else begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s_q == S_BIT) begin
              sh_q <= {bit_v, sh_q[DBIT-1:1]};
              s_q  <= '0;
              if (n_q == N_LAST) begin
                state_q <= par_en ? PARITY : STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bus.s_tick) begin
            if (s_q == S_BIT) begin
              pbit_q  <= bit_v;
              perr_q  <= ((^sh_q) ^ bit_v) != (mode_q == PAR_ODD);
              s_q     <= '0;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (s_q == S_SSMP) begin
              stop_low_q <= ~bit_v;
            end
            if (s_q == S_END) begin
              state_q      <= IDLE;
              done_q       <= 1'b1;
              dout_q       <= sh_q;
              parity_err_q <= par_en & perr_q;
              frame_err_q  <= ferr_now;
              break_det_q  <= ferr_now && (sh_q == '0) && !(par_en && pbit_q);
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_done_tick = done_q;
  assign bus.dout         = dout_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.break_det    = break_det_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: line waveforms are built per s_tick, decoded
// by a tick-indexed reference model into expected frames, then played to the DUT.
module tb_uart_rx_cfg;

  localparam int DBIT    = 8;
  localparam int OVS     = 16;
  localparam int SB_TICK = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
  localparam int CHK = OVS / 2;
`else
  localparam bit MAJ = 1'b0;
  localparam int CHK = OVS / 2 - 1;
`endif
  localparam int STOP_POS = (SB_TICK < OVS) ? SB_TICK : OVS;

  typedef struct packed {
    logic [DBIT-1:0] d;
    logic            pe;
    logic            fe;
    logic            bk;
  } res_t;

  res_t exp_q[$];
  bit   line_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   tick_div = 0;
  logic clk      = 1'b0;
  logic reset_n;

  uart_rx_cfg_if #(.DBIT(DBIT)) bus ();

  uart_rx_cfg #(
    .DBIT    (DBIT),
    .OVS     (OVS),
    .SB_TICK (SB_TICK)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // One s_tick every four clocks, changed on the falling edge.
  always @(negedge clk) tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
  assign bus.s_tick = (tick_div == 3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is compared against the oldest expected frame.
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_done: got pulse dout=0x%0h expected none at %0t", bus.dout, $time);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("dout",       32'(bus.dout),       32'(e.d));
        check("parity_err", 32'(bus.parity_err), 32'(e.pe));
        check("frame_err",  32'(bus.frame_err),  32'(e.fe));
        check("break_det",  32'(bus.break_det),  32'(e.bk));
      end
    end
  end

  // ---------------- reference model ----------------
  // line_q[i] is the level present on rx just before tick i; outside the
  // waveform the line idles high.
  function automatic bit line_at(input int i);
    if (i < 0 || i >= line_q.size()) return 1'b1;
    return line_q[i];
  endfunction

  function automatic bit vote(input int i);
    bit a, b, c;
    a = line_at(i - 2);
    b = line_at(i - 1);
    c = line_at(i);
    if (MAJ) return (a & b) | (a & c) | (b & c);
    return c;
  endfunction

  task automatic model(input int mode);
    int  t     = 0;
    bit  force_start = 1'b0;
    bit  pen   = (mode == 1) || (mode == 2);
    while (t < line_q.size()) begin
      int c;
      logic [DBIT-1:0] d;
      bit p, fe;
      res_t r;
      if (!force_start && line_at(t)) begin
        t++;
        continue;
      end
      force_start = 1'b0;
      c = t + CHK;
      if (vote(c)) begin
        // False start: a line still low at the return tick restarts at once.
        force_start = !line_at(c);
        t = c + 1;
        continue;
      end
      d = '0;
      for (int k = 0; k < DBIT; k++) begin
        c += OVS;
        d[k] = vote(c);
      end
      p = 1'b0;
      r.pe = 1'b0;
      if (pen) begin
        c += OVS;
        p = vote(c);
        r.pe = ((^d) ^ p) != (mode == 2);
      end
      fe   = !vote(c + STOP_POS);
      r.d  = d;
      r.fe = fe;
      r.bk = fe && (d == '0) && !(pen && p);
      exp_q.push_back(r);
      c += SB_TICK;
      force_start = !line_at(c);
      t = c + 1;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic add_level(input bit v, input int n);
    repeat (n) line_q.push_back(v);
  endtask

  task automatic add_frame(input logic [DBIT-1:0] d, input int mode, input bit flip, input bit stop_v);
    add_level(1'b0, OVS);
    for (int k = 0; k < DBIT; k++) add_level(d[k], OVS);
    if (mode == 1 || mode == 2) add_level((^d) ^ (mode == 2) ^ flip, OVS);
    add_level(stop_v, SB_TICK);
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!bus.s_tick) @(posedge clk);
    #1;
  endtask

  task automatic play();
    for (int i = 0; i < line_q.size(); i++) begin
      bus.rx = line_q[i];
      wait_tick();
    end
    bus.rx = 1'b1;
  endtask

  task automatic run_scn(input string name, input int mode);
    bus.parity_mode = 2'(mode);
    model(mode);
    play();
    repeat ((DBIT + 6) * OVS) wait_tick();
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    line_q.delete();
  endtask

  task automatic check_cleared(input string name);
    check({name, "_done"}, 32'(bus.rx_done_tick), 32'd0);
    check({name, "_dout"}, 32'(bus.dout),         32'd0);
    check({name, "_perr"}, 32'(bus.parity_err),   32'd0);
    check({name, "_ferr"}, 32'(bus.frame_err),    32'd0);
    check({name, "_brk"},  32'(bus.break_det),    32'd0);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.rx          = 1'b1;
    bus.parity_mode = 2'b00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    #2 reset_n = 1'b1;
    repeat (4) wait_tick();

    // Plain 8N1 frame.
    add_level(1'b1, 2 * OVS);
    add_frame(8'hA5, 0, 1'b0, 1'b1);
    add_level(1'b1, 2 * OVS);
    run_scn("a5_8n1", 0);

    // Even parity, wrong then right parity bit.
    add_level(1'b1, 2 * OVS);
    add_frame(8'h37, 1, 1'b1, 1'b1);
    add_level(1'b1, 2 * OVS);
    add_frame(8'h37, 1, 1'b0, 1'b1);
    add_level(1'b1, 2 * OVS);
    run_scn("even_37", 1);

    // Break: 12 bit times low, long idle, then a clean frame.
    add_level(1'b1, 2 * OVS);
    add_level(1'b0, 12 * OVS);
    add_level(1'b1, 12 * OVS);
    add_frame(8'h5A, 0, 1'b0, 1'b1);
    add_level(1'b1, 2 * OVS);
    run_scn("break", 0);

    // Four-tick glitch must be rejected as a false start.
    add_level(1'b1, 2 * OVS);
    add_level(1'b0, 4);
    add_level(1'b1, 20 * OVS);
    run_scn("glitch", 0);
    add_frame(8'hC3, 0, 1'b0, 1'b1);
    add_level(1'b1, 2 * OVS);
    run_scn("c3_after_glitch", 0);

    // Reset in the middle of the data bits of 0xFF.
    add_level(1'b0, OVS);
    add_level(1'b1, 3 * OVS);
    play();
    line_q.delete();
    bus.rx  = 1'b0;
    #3 reset_n = 1'b0;
    @(negedge clk);
    check_cleared("mid_reset");
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (4) wait_tick();
    add_level(1'b1, 2 * OVS);
    add_frame(8'h3C, 0, 1'b0, 1'b1);
    add_level(1'b1, 2 * OVS);
    run_scn("3c_after_reset", 0);

    // One-tick high glitch at the centre of bit 0 of 0x00.
    add_level(1'b1, 2 * OVS);
    add_level(1'b0, OVS);
    add_level(1'b0, OVS / 2 - 1);
    add_level(1'b1, 1);
    add_level(1'b0, OVS / 2);
    add_level(1'b0, (DBIT - 1) * OVS);
    add_level(1'b1, SB_TICK);
    add_level(1'b1, 2 * OVS);
    run_scn("centre_glitch", 0);

    // Random frames, one batch per parity mode including the reserved code.
    for (int m = 0; m < 4; m++) begin
      add_level(1'b1, 2 * OVS);
      for (int f = 0; f < 8; f++) begin
        add_frame(DBIT'($urandom), m, ($urandom % 4) == 0, ($urandom % 8) != 0);
        add_level(1'b1, $urandom_range(0, 2 * OVS));
      end
      add_level(1'b1, 2 * OVS);
      run_scn("random", m);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised next-generation UART receiver. Generalises the fixed 8-bit, no-parity receiver to configurable data width, oversampling ratio and stop length. Adds runtime parity selection, false-start rejection, an input synchroniser, and parity/framing/break error reporting. Sits between the pad-side rx line and the shared baud-tick generator (s_tick) and feeds the RX FIFO or host interface.

Parameters:
DBIT, 8, data bits per frame; legal range 5..9.
OVS, 16, s_tick pulses per bit period; even, at least 8.
SB_TICK, 16, s_tick pulses in the stop phase; OVS = 1 stop bit, 1.5*OVS = 1.5 bits, 2*OVS = 2 bits.

Ports:
clk  in  1  system clock, single clock domain
reset_n  in  1  asynchronous, active-low reset
rx  in  1  serial input; asynchronous, idle high
s_tick  in  1  oversampling enable, one clk wide, OVS pulses per bit
parity_mode  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none); latched at start detect
rx_done_tick  out  1  one-clk pulse; frame complete; dout and error flags valid
dout  out  DBIT  received data, LSB first on the line; held until the next rx_done_tick
parity_err  out  1  parity mismatch on the last frame; held with dout
frame_err  out  1  first stop-bit sample low on the last frame; held with dout
break_det  out  1  frame_err set and all data bits 0 (and parity bit 0 if enabled); held with dout

Behaviour:
- Reset (reset_n low, any time, including mid-frame):
  - state IDLE, all counters 0, synchroniser flops 1.
  - dout 0; rx_done_tick, parity_err, frame_err and break_det all 0.
  - Release: the next frame is received normally.
- rx passes through a 2-flop synchroniser. All decisions below use the synchronised rx_s.
- States: IDLE, START, DATA, PARITY, STOP. All counting advances only on s_tick. With s_tick low, state and counters hold.
- IDLE:
  - rx_s == 0 -> START, s = 0, latch parity_mode.
  - Detection does not wait for s_tick.
- START:
  - On each s_tick: if s == OVS/2-1, check rx_s.
  - rx_s == 1 -> false start, return to IDLE, no pulse or flag.
  - rx_s == 0 -> DATA, s = 0, n = 0.
  - Otherwise s++.
- DATA:
  - On each s_tick: at s == OVS-1 (bit centre), shift the sample into the MSB of the DBIT shift register (right shift), s = 0.
  - If n == DBIT-1: go to PARITY when the latched mode is even or odd, else STOP. Otherwise n++.
  - Else s++.
- PARITY:
  - At s == OVS-1, sample bit p, s = 0, go to STOP.
  - Error if XOR(data, p) is not 0 (even) or not 1 (odd).
- STOP:
  - At s == OVS-1, sample the first stop bit and record frame error if low.
  - At s == SB_TICK-1: go to IDLE; register dout, parity_err, frame_err and break_det; pulse rx_done_tick.
  - For SB_TICK < OVS, the stop sample is taken at s == SB_TICK-1.
- Latency: rx_done_tick and updated outputs appear on the clk edge after the s_tick that ends STOP.
- Line low at return to IDLE (break, or back-to-back frame): IDLE sees rx_s == 0 on the next clk and starts a new frame.
- Counter widths: s is clog2(max(OVS, SB_TICK)) bits, n is clog2(DBIT) bits. Wrap never occurs; comparisons are exact.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each data, parity and stop bit value is the 2-of-3 majority of rx_s sampled at s == OVS/2-2, OVS/2-1 and OVS/2. The bit still commits at s == OVS-1. The start check uses the same majority.
- Undefined: one sample per bit at the commit point (start check at s == OVS/2-1). The sample registers are not instantiated.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE/START/DATA/PARITY/STOP;
  - parity_mode encodings PAR_NONE/PAR_EVEN/PAR_ODD;
  - a function for the counter width.
- One sub-module, uart_rx_sampler: 2-flop synchroniser plus the optional majority voter. Outputs rx_s and the voted bit.
- The FSM and datapath stay in uart_rx_cfg.

Test Plan:
1. DBIT=8, OVS=16, mode none, send 0xA5 8N1 -> one rx_done_tick; dout=0xA5; parity_err, frame_err and break_det all 0.
2. Mode even, send 0x37 with parity bit 0 (correct bit is 1) -> dout=0x37, parity_err=1, frame_err=0. Resend with parity bit 1 -> parity_err=0.
3. Hold rx low for 12 bit times -> dout=0x00, frame_err=1, break_det=1. After rx returns high, 0x5A is received cleanly with flags 0.
4. Glitch rx low for 4 s_ticks in IDLE -> back to IDLE; no rx_done_tick for 2 frame times; a following 0xC3 is received correctly.
5. Assert reset_n low mid-DATA of 0xFF -> all outputs 0, no pulse. After release, 0x3C is received with dout=0x3C.
6. With UART_RX_MAJORITY_EN, add a 1-tick high glitch at s=OVS/2-1 in bit 0 of 0x00 -> dout=0x00. Without the macro, the same stimulus gives dout=0x01.
